// File: rtl/ooo_issue_buffer_pkg.sv
// Shared types for the out-of-order issue buffer: entry index type and
// the per-entry status record.
package ooo_issue_buffer_pkg;

  // Default number of entries and the matching index width.
  localparam int IB_DEPTH = 8;
  localparam int IB_IDX_W = $clog2(IB_DEPTH);

  // Entry index for a buffer of IB_DEPTH entries.
  typedef logic [IB_IDX_W-1:0] idx_t;

  // Per-entry status: occupied, and eligible for issue.
  typedef struct packed {
    logic valid;
    logic ready;
  } entry_status_t;

endpackage

// File: rtl/ooo_issue_buffer_lowest_n_picker.sv
// Returns N one-hot masks selecting the N lowest set bits of a request
// vector, lowest first. A mask is all zero when fewer than k+1 bits are set.
module lowest_n_picker #(
  parameter int WIDTH = 8,
  parameter int N     = 2
) (
  input  logic [WIDTH-1:0]        req,
  output logic [N-1:0][WIDTH-1:0] masks
);

  // Isolate the lowest remaining bit, then strip it and repeat.
  always_comb begin
    logic [WIDTH-1:0] rem;
    rem   = req;
    masks = '0;
    for (int k = 0; k < N; k++) begin
      masks[k] = rem & (~rem + {{(WIDTH-1){1'b0}}, 1'b1});
      rem      = rem & ~masks[k];
    end
  end

endmodule

// File: rtl/ooo_issue_buffer.sv
// Out-of-order issue buffer. Entries are allocated to the lowest free
// slots, become ready at write or by wakeup, and issue lowest-index first
// across several dequeue ports. Selection uses registered state only, so
// there is no enqueue-to-dequeue bypass.
module ooo_issue_buffer
  import ooo_issue_buffer_pkg::*;
#(
  parameter int DEPTH      = IB_DEPTH,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush_i,
  input  logic [ENQ_WIDTH-1:0]                       enq_vld_i,
  output logic [ENQ_WIDTH-1:0]                       enq_rdy_o,
  input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]       enq_data_i,
  input  logic [ENQ_WIDTH-1:0]                       enq_ready_i,
  output logic [ENQ_WIDTH-1:0][$clog2(DEPTH)-1:0]    enq_idx_o,
  input  logic                                       wake_vld_i,
  input  logic [$clog2(DEPTH)-1:0]                   wake_idx_i,
  output logic [DEQ_WIDTH-1:0]                       deq_vld_o,
  input  logic [DEQ_WIDTH-1:0]                       deq_rdy_i,
  output logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0]       deq_data_o,
  output logic [DEQ_WIDTH-1:0][$clog2(DEPTH)-1:0]    deq_idx_o,
  output logic [$clog2(DEPTH):0]                     count_o,
  output logic                                       full_o,
  output logic                                       empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  entry_status_t [DEPTH-1:0]          status_r;
  entry_status_t [DEPTH-1:0]          status_nxt_s;
  logic [DATA_WIDTH-1:0]              data_r [DEPTH];
  logic [CW-1:0]                      count_r;
  logic [CW-1:0]                      count_nxt_s;

  logic [DEPTH-1:0]                   free_vec_s;
  logic [DEPTH-1:0]                   cand_vec_s;
  logic [ENQ_WIDTH-1:0][DEPTH-1:0]    alloc_mask_s;
  logic [DEQ_WIDTH-1:0][DEPTH-1:0]    sel_mask_s;

  logic [ENQ_WIDTH-1:0]               enq_rdy_s;
  logic [ENQ_WIDTH-1:0]               enq_fire_s;
  logic [ENQ_WIDTH-1:0][IW-1:0]       enq_idx_s;
  logic [DEQ_WIDTH-1:0]               deq_vld_s;
  logic [DEQ_WIDTH-1:0]               deq_fire_s;
  logic [DEQ_WIDTH-1:0][IW-1:0]       deq_idx_s;
  logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0] deq_data_s;

  logic [DEPTH-1:0]                   wake_hit_s;
  logic [DEPTH-1:0]                   deq_hit_s;
  logic [DEPTH-1:0]                   enq_hit_s;
  logic [DEPTH-1:0]                   enq_rdy_val_s;

  // Split status into the free vector (allocation) and candidate vector (issue).
  always_comb begin
    free_vec_s = '0;
    cand_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec_s[i] = ~status_r[i].valid;
      cand_vec_s[i] = status_r[i].valid & status_r[i].ready;
    end
  end

  lowest_n_picker #(
    .WIDTH (DEPTH),
    .N     (ENQ_WIDTH)
  ) u_alloc_picker (
    .req   (free_vec_s),
    .masks (alloc_mask_s)
  );

  lowest_n_picker #(
    .WIDTH (DEPTH),
    .N     (DEQ_WIDTH)
  ) u_sel_picker (
    .req   (cand_vec_s),
    .masks (sel_mask_s)
  );

  // Per enqueue port: fixed slot index, readiness and fire.
  always_comb begin
    enq_idx_s  = '0;
    enq_rdy_s  = '0;
    enq_fire_s = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        enq_idx_s[k] = enq_idx_s[k] | (IW'(i) & {IW{alloc_mask_s[k][i]}});
      end
      enq_rdy_s[k]  = (|alloc_mask_s[k]) & ~flush_i;
      enq_fire_s[k] = enq_vld_i[k] & enq_rdy_s[k];
    end
  end

  // Per dequeue port: selected entry, its payload, and fire.
  always_comb begin
    deq_idx_s  = '0;
    deq_data_s = '0;
    deq_vld_s  = '0;
    deq_fire_s = '0;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        deq_idx_s[j]  = deq_idx_s[j]  | (IW'(i) & {IW{sel_mask_s[j][i]}});
        deq_data_s[j] = deq_data_s[j] | (data_r[i] & {DATA_WIDTH{sel_mask_s[j][i]}});
      end
      deq_vld_s[j]  = (|sel_mask_s[j]) & ~flush_i;
      deq_fire_s[j] = deq_vld_s[j] & deq_rdy_i[j];
    end
  end

  // Per-entry events this cycle: wakeup, dequeue, enqueue.
  always_comb begin
    wake_hit_s    = '0;
    deq_hit_s     = '0;
    enq_hit_s     = '0;
    enq_rdy_val_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_hit_s[i] = wake_vld_i & (wake_idx_i == IW'(i)) & status_r[i].valid;
      for (int j = 0; j < DEQ_WIDTH; j++) begin
        deq_hit_s[i] = deq_hit_s[i] | (deq_fire_s[j] & sel_mask_s[j][i]);
      end
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        enq_hit_s[i]     = enq_hit_s[i] | (enq_fire_s[k] & alloc_mask_s[k][i]);
        enq_rdy_val_s[i] = enq_rdy_val_s[i]
                         | (enq_fire_s[k] & alloc_mask_s[k][i] & enq_ready_i[k]);
      end
    end
  end

  // Next entry status; enqueue only targets free entries, dequeue/wakeup only valid ones.
  always_comb begin
    status_nxt_s = status_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_i) begin
        status_nxt_s[i] = '0;
      end else if (enq_hit_s[i]) begin
        status_nxt_s[i].valid = 1'b1;
        status_nxt_s[i].ready = enq_rdy_val_s[i];
      end else if (deq_hit_s[i]) begin
        status_nxt_s[i] = '0;
      end else begin
        status_nxt_s[i].valid = status_r[i].valid;
        status_nxt_s[i].ready = status_r[i].ready | wake_hit_s[i];
      end
    end
  end

  // Next occupancy count from accepted enqueues and dequeues.
  always_comb begin
    count_nxt_s = count_r;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      count_nxt_s = count_nxt_s + CW'(enq_fire_s[k]);
    end
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      count_nxt_s = count_nxt_s - CW'(deq_fire_s[j]);
    end
    if (flush_i) begin
      count_nxt_s = '0;
    end else begin
      count_nxt_s = count_nxt_s;
    end
  end

  // Status and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= '0;
      count_r  <= '0;
    end else begin
      status_r <= status_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Payload storage; contents of free entries are irrelevant, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (enq_fire_s[k]) begin
        data_r[enq_idx_s[k]] <= enq_data_i[k];
      end
    end
  end

  assign enq_rdy_o  = enq_rdy_s;
  assign enq_idx_o  = enq_idx_s;
  assign deq_vld_o  = deq_vld_s;
  assign deq_idx_o  = deq_idx_s;
  assign deq_data_o = deq_data_s;
  assign count_o    = count_r;
  assign full_o     = (count_r == CW'(DEPTH));
  assign empty_o    = (count_r == {CW{1'b0}});

endmodule

// File: tb/tb_ooo_issue_buffer.sv
// Scoreboard bench for ooo_issue_buffer: a stimulus thread drives inputs and
// pushes the reference model's expected outputs; a monitor thread pops and
// compares them against the DUT every cycle.
module tb_ooo_issue_buffer;

  localparam int DEPTH = 8;
  localparam int EW    = 2;
  localparam int DW    = 2;
  localparam int DATAW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      flush_i;
  logic [EW-1:0]             enq_vld_i;
  logic [EW-1:0]             enq_rdy_o;
  logic [EW-1:0][DATAW-1:0]  enq_data_i;
  logic [EW-1:0]             enq_ready_i;
  logic [EW-1:0][2:0]        enq_idx_o;
  logic                      wake_vld_i;
  logic [2:0]                wake_idx_i;
  logic [DW-1:0]             deq_vld_o;
  logic [DW-1:0]             deq_rdy_i;
  logic [DW-1:0][DATAW-1:0]  deq_data_o;
  logic [DW-1:0][2:0]        deq_idx_o;
  logic [3:0]                count_o;
  logic                      full_o;
  logic                      empty_o;

  ooo_issue_buffer #(
    .DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .DATA_WIDTH(DATAW)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_vld_i(enq_vld_i), .enq_rdy_o(enq_rdy_o), .enq_data_i(enq_data_i),
    .enq_ready_i(enq_ready_i), .enq_idx_o(enq_idx_o),
    .wake_vld_i(wake_vld_i), .wake_idx_i(wake_idx_i),
    .deq_vld_o(deq_vld_o), .deq_rdy_i(deq_rdy_i), .deq_data_o(deq_data_o),
    .deq_idx_o(deq_idx_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct packed {
    logic [1:0]        enq_rdy;
    logic [1:0][2:0]   enq_idx;
    logic [1:0]        deq_vld;
    logic [1:0][2:0]   deq_idx;
    logic [1:0][31:0]  deq_data;
    logic [3:0]        count;
    logic              full;
    logic              empty;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain arrays of occupancy, readiness and payload.
  bit [7:0]    m_valid;
  bit [7:0]    m_ready;
  logic [31:0] m_data [8];
  bit          m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs: free list and ready list in ascending index order.
  function automatic exp_t model_expect(input bit flush);
    int   free_l[$];
    int   rdy_l[$];
    int   cnt;
    exp_t e;
    e   = '0;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_valid[i]) free_l.push_back(i);
      else cnt++;
      if (m_valid[i] && m_ready[i]) rdy_l.push_back(i);
    end
    for (int k = 0; k < EW; k++) begin
      if (!flush && free_l.size() > k) begin
        e.enq_rdy[k] = 1'b1;
        e.enq_idx[k] = 3'(free_l[k]);
      end
    end
    for (int j = 0; j < DW; j++) begin
      if (!flush && rdy_l.size() > j) begin
        e.deq_vld[j]  = 1'b1;
        e.deq_idx[j]  = 3'(rdy_l[j]);
        e.deq_data[j] = m_data[rdy_l[j]];
      end
    end
    e.count = 4'(cnt);
    e.full  = (cnt == DEPTH);
    e.empty = (cnt == 0);
    return e;
  endfunction

  // One cycle of stimulus: drive, record expectation, advance model.
  task automatic step(input bit r, input bit f, input bit [1:0] ev, input bit [1:0] er,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input bit wv, input bit [2:0] wi, input bit [1:0] dr);
    exp_t     e;
    bit [7:0] nv;
    bit [7:0] nr;
    int       ix;
    @(negedge clk);
    rst = r; flush_i = f; enq_vld_i = ev; enq_ready_i = er;
    enq_data_i[0] = d0; enq_data_i[1] = d1;
    wake_vld_i = wv; wake_idx_i = wi; deq_rdy_i = dr;
    #1;
    e = model_expect(f);
    if (m_known) exp_q.push_back(e);
    if (r || f) begin
      m_valid = '0;
      m_ready = '0;
      if (r) m_known = 1'b1;
    end else begin
      nv = m_valid;
      nr = m_ready;
      if (wv && m_valid[wi]) nr[wi] = 1'b1;
      for (int j = 0; j < DW; j++) begin
        if (dr[j] && e.deq_vld[j]) begin
          ix = int'(e.deq_idx[j]);
          nv[ix] = 1'b0;
          nr[ix] = 1'b0;
        end
      end
      for (int k = 0; k < EW; k++) begin
        if (ev[k] && e.enq_rdy[k]) begin
          ix = int'(e.enq_idx[k]);
          nv[ix] = 1'b1;
          nr[ix] = er[k];
          m_data[ix] = (k == 0) ? d0 : d1;
        end
      end
      m_valid = nv;
      m_ready = nr;
    end
  endtask

  task automatic idle(input bit wv, input bit [2:0] wi, input bit [1:0] dr);
    step(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, wv, wi, dr);
  endtask

  task automatic fill(input bit [1:0] ev, input bit [1:0] er);
    step(1'b0, 1'b0, ev, er, $urandom, $urandom, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic do_flush();
    step(1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 3'd0, 2'b00);
  endtask

  // Monitor: compare whatever the DUT presents against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("enq_rdy", 32'(enq_rdy_o), 32'(e.enq_rdy));
        for (int k = 0; k < EW; k++)
          if (e.enq_rdy[k]) chk("enq_idx", 32'(enq_idx_o[k]), 32'(e.enq_idx[k]));
        chk("deq_vld", 32'(deq_vld_o), 32'(e.deq_vld));
        for (int j = 0; j < DW; j++) begin
          if (e.deq_vld[j]) begin
            chk("deq_idx", 32'(deq_idx_o[j]), 32'(e.deq_idx[j]));
            chk("deq_data", deq_data_o[j], e.deq_data[j]);
          end
        end
        chk("count", 32'(count_o), 32'(e.count));
        chk("full", 32'(full_o), 32'(e.full));
        chk("empty", 32'(empty_o), 32'(e.empty));
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int pe;
    int pd;
    bit [1:0] ev;
    bit [1:0] dr;
    rst = 1'b1; flush_i = 1'b0; enq_vld_i = '0; enq_ready_i = '0; enq_data_i = '0;
    wake_vld_i = 1'b0; wake_idx_i = '0; deq_rdy_i = '0;

    step(1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 3'd0, 2'b00);
    step(1'b1, 1'b0, 2'b11, 2'b11, 32'h1, 32'h2, 1'b1, 3'd0, 2'b11);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_enq_rdy", 32'(enq_rdy_o), 32'h3);
    chk("rst_deq_vld", 32'(deq_vld_o), 32'h0);

    // Two ready entries become issue candidates one cycle after enqueue.
    step(1'b0, 1'b0, 2'b11, 2'b11, 32'hA, 32'hB, 1'b0, 3'd0, 2'b00);
    chk("basic_idx0", 32'(enq_idx_o[0]), 32'd0);
    chk("basic_idx1", 32'(enq_idx_o[1]), 32'd1);
    chk("basic_no_bypass", 32'(deq_vld_o), 32'h0);
    idle(1'b0, 3'd0, 2'b00);
    chk("basic_deq_vld", 32'(deq_vld_o), 32'h3);
    chk("basic_data0", deq_data_o[0], 32'hA);
    chk("basic_data1", deq_data_o[1], 32'hB);
    chk("basic_count", 32'(count_o), 32'd2);

    // Fill with not-ready entries, then wake entry 5.
    do_flush();
    repeat (4) fill(2'b11, 2'b00);
    idle(1'b1, 3'd5, 2'b00);
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_enq_rdy", 32'(enq_rdy_o), 32'h0);
    chk("full_deq_vld", 32'(deq_vld_o), 32'h0);
    idle(1'b0, 3'd0, 2'b00);
    chk("wake_deq_vld0", 32'(deq_vld_o[0]), 32'd1);
    chk("wake_deq_idx0", 32'(deq_idx_o[0]), 32'd5);

    // Flush wins over same-cycle enqueue and dequeue.
    step(1'b0, 1'b1, 2'b11, 2'b11, 32'h5, 32'h6, 1'b0, 3'd0, 2'b11);
    idle(1'b0, 3'd0, 2'b00);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_empty", 32'(empty_o), 32'd1);

    // Wakeup of a free index does not affect a same-cycle enqueue there.
    fill(2'b11, 2'b00);
    fill(2'b01, 2'b00);
    step(1'b0, 1'b0, 2'b01, 2'b00, 32'h33, 32'h0, 1'b1, 3'd3, 2'b00);
    chk("wake_free_idx", 32'(enq_idx_o[0]), 32'd3);
    idle(1'b0, 3'd0, 2'b00);
    chk("wake_free_notrdy", 32'(deq_vld_o), 32'h0);

    // Nearly full: only port 0 ready; entry freed this cycle not reused yet.
    do_flush();
    repeat (3) fill(2'b11, 2'b11);
    fill(2'b01, 2'b11);
    step(1'b0, 1'b0, 2'b11, 2'b11, 32'h77, 32'h88, 1'b0, 3'd0, 2'b01);
    chk("nf_enq_rdy", 32'(enq_rdy_o), 32'h1);
    chk("nf_enq_idx", 32'(enq_idx_o[0]), 32'd7);
    chk("nf_deq_idx", 32'(deq_idx_o[0]), 32'd0);
    idle(1'b0, 3'd0, 2'b00);
    chk("nf_reuse_idx", 32'(enq_idx_o[0]), 32'd0);
    chk("nf_count", 32'(count_o), 32'd7);

    // Independent dequeue ports: port 1 fires while port 0 stalls.
    do_flush();
    repeat (3) fill(2'b11, 2'b00);
    fill(2'b01, 2'b00);
    idle(1'b1, 3'd2, 2'b00);
    idle(1'b1, 3'd4, 2'b00);
    idle(1'b1, 3'd6, 2'b00);
    idle(1'b0, 3'd0, 2'b10);
    chk("port1_idx", 32'(deq_idx_o[1]), 32'd4);
    idle(1'b0, 3'd0, 2'b00);
    chk("after_p1_idx0", 32'(deq_idx_o[0]), 32'd2);
    chk("after_p1_idx1", 32'(deq_idx_o[1]), 32'd6);

    // Randomized traffic with phases biased toward fill or drain.
    for (int n = 0; n < 3000; n++) begin
      case ((n / 150) % 3)
        0:       begin pe = 80; pd = 20; end
        1:       begin pe = 30; pd = 80; end
        default: begin pe = 50; pd = 50; end
      endcase
      for (int k = 0; k < 2; k++) ev[k] = ($urandom_range(0, 99) < pe);
      for (int j = 0; j < 2; j++) dr[j] = ($urandom_range(0, 99) < pd);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 59) == 0, ev,
           2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), dr);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
